// File: rtl/xorshift_pkg.sv
// Shared Xorshift32 definitions for the generator and checker.
//   XS_A / XS_B / XS_C : shift amounts of the Xorshift32 step
//   xs_state_e         : checker FSM states with fixed debug encoding
//   xs_next()          : one Xorshift32 step, 32-bit truncating
package xorshift_pkg;

    localparam int unsigned XS_A = 13;
    localparam int unsigned XS_B = 17;
    localparam int unsigned XS_C = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } xs_state_e;

    function automatic logic [31:0] xs_next(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

endpackage

// File: rtl/xorshift32_next.sv
// Purely combinational Xorshift32 step.
//   x_i : current 32-bit state
//   y_o : next 32-bit state
module xorshift32_next
    import xorshift_pkg::*;
(
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = xs_next(x_i);
    end

endmodule

// File: rtl/xorshift32_checker.sv
// Self-synchronising Xorshift32 stream checker with flywheel lock hold
// and saturating match/error statistics.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   clr       : synchronous clear of match_cnt / err_cnt only
//   in_valid  : in_data carries a word this cycle (no backpressure)
//   in_data   : received 32-bit word
//   locked    : FSM is in LOCKED
//   err       : one-cycle pulse for a mismatch accepted while LOCKED
//   match_cnt : saturating count of matching words while LOCKED
//   err_cnt   : saturating count of mismatching words while LOCKED
//   state     : FSM state encoding for debug
module xorshift32_checker
    import xorshift_pkg::*;
#(
    parameter int unsigned CONFIRM_N = 2,
    parameter int unsigned LOSS_N    = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned OK_W  = (CONFIRM_N < 2) ? 1 : $clog2(CONFIRM_N + 1);
    localparam int unsigned BAD_W = (LOSS_N < 2) ? 1 : $clog2(LOSS_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    xs_state_e        state_q, state_d;
    logic [31:0]      pred_q, pred_d;
    logic [OK_W-1:0]  ok_q, ok_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic             locked_q, err_q, err_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d, ecnt_q, ecnt_d;

    logic [31:0] next_in, next_pred;
    logic        hit;

    // Re-seed / match path
    xorshift32_next u_next_in (
        .x_i (in_data),
        .y_o (next_in)
    );

    // Flywheel path: advance the prediction without trusting the word
    xorshift32_next u_next_pred (
        .x_i (pred_q),
        .y_o (next_pred)
    );

    assign hit = (in_data == pred_q);

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        ok_d    = ok_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        mcnt_d  = mcnt_q;
        ecnt_d  = ecnt_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    // Zero is the generator's fixed point and cannot seed
                    if (in_data != '0) begin
                        pred_d  = next_in;
                        ok_d    = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        pred_d = next_in;
                        ok_d   = ok_q + OK_W'(1);
                        if (ok_q == OK_W'(CONFIRM_N - 1)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else if (in_data == '0) begin
                        state_d = HUNT;
                    end else begin
                        pred_d = next_in;
                        ok_d   = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        pred_d = next_in;
                        bad_d  = '0;
                        if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + CNT_W'(1);
                    end else begin
                        pred_d = next_pred;
                        bad_d  = bad_q + BAD_W'(1);
                        err_d  = 1'b1;
                        if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_W'(1);
                        if (bad_q == BAD_W'(LOSS_N - 1)) state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear overrides any simultaneous count
        if (clr) begin
            mcnt_d = '0;
            ecnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            ok_q     <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            mcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
            mcnt_q   <= mcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign match_cnt = mcnt_q;
    assign err_cnt   = ecnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_xorshift32_checker.sv
module tb_xorshift32_checker;

    localparam int unsigned CN   = 2;
    localparam int unsigned LN   = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned MAXC = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        locked, err;
    logic [CW-1:0] match_cnt, err_cnt;
    logic [1:0]  state;

    xorshift32_checker #(.CONFIRM_N(CN), .LOSS_N(LN), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err       (err),
        .match_cnt (match_cnt),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk;
        logic        er;
        logic [31:0] mc;
        logic [31:0] ec;
        logic [31:0] st;
        int unsigned id;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int unsigned next_id = 0;

    // Reference model: mode 0=hunting, 1=verifying, 2=locked
    int          m_mode = 0;
    logic [31:0] m_pred = '0;
    int          m_good = 0;
    int          m_bad  = 0;
    int          m_mc   = 0;
    int          m_ec   = 0;
    logic        m_er   = 1'b0;
    logic [31:0] g;

    function automatic logic [31:0] nx(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] d, input logic c, input logic r);
        if (!r) begin
            m_mode = 0; m_pred = '0; m_good = 0; m_bad = 0;
            m_mc = 0; m_ec = 0; m_er = 1'b0;
            return;
        end
        m_er = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin m_pred = nx(d); m_good = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_pred = nx(d); m_good++;
                    if (m_good == CN) begin m_mode = 2; m_bad = 0; end
                end else if (d == 0) begin
                    m_mode = 0;
                end else begin
                    m_pred = nx(d); m_good = 0;
                end
            end else begin
                if (d == m_pred) begin
                    m_pred = nx(d); m_bad = 0;
                    if (m_mc < MAXC) m_mc++;
                end else begin
                    m_pred = nx(m_pred); m_bad++; m_er = 1'b1;
                    if (m_ec < MAXC) m_ec++;
                    if (m_bad == LN) m_mode = 0;
                end
            end
        end
        if (c) begin m_mc = 0; m_ec = 0; end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; clr = c; rst = r;
        model_step(v, d, c, r);
        e.lk = (m_mode == 2);
        e.er = m_er;
        e.mc = 32'(m_mc);
        e.ec = 32'(m_ec);
        e.st = 32'(m_mode);
        e.id = next_id;
        next_id++;
        sbq.push_back(e);
    endtask

    task automatic send_gen();
        g = nx(g);
        drive(1'b1, g, 1'b0, 1'b1);
    endtask

    task automatic gap();
        drive(1'b0, $urandom, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int unsigned id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle_id=%0d got=%0h expected=%0h", name, id, got, want);
        end
    endtask

    // Monitor: every registered output is present each cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("locked",    e.id, 32'(locked),    32'(e.lk));
                chk("err",       e.id, 32'(err),       32'(e.er));
                chk("match_cnt", e.id, 32'(match_cnt), e.mc);
                chk("err_cnt",   e.id, 32'(err_cnt),   e.ec);
                chk("state",     e.id, 32'(state),     e.st);
            end
        end
    end

    initial begin
        logic [31:0] w;
        int unsigned r;

        // Reset
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Zero word in HUNT is ignored
        drive(1'b1, '0, 1'b0, 1'b1);
        gap();

        // Lock acquisition with random gaps
        g = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            send_gen();
            if ($urandom_range(0, 1) == 1) gap();
        end

        // Single corruption, flywheel keeps lock
        g = nx(g);
        drive(1'b1, g ^ 32'h1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_gen();

        // Loss of lock after LOSS_N random words, then relock
        drive(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_gen();

        // VERIFY re-seed on a wrong word
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h12345678, 1'b0, 1'b1);
        w = $urandom | 32'h1;
        drive(1'b1, w, 1'b0, 1'b1);
        g = w;
        for (int i = 0; i < 3; i++) send_gen();

        // Saturation with toggling valid, then clr with a match
        for (int i = 0; i < 20; i++) begin
            send_gen();
            gap();
        end
        g = nx(g);
        drive(1'b1, g, 1'b1, 1'b1);
        send_gen();

        // Reset mid-stream while locked
        g = nx(g);
        drive(1'b1, g, 1'b0, 1'b0);
        gap();
        for (int i = 0; i < 3; i++) send_gen();

        // Randomised mix
        g = $urandom | 32'h1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) send_gen();
            else if (r < 70) gap();
            else if (r < 78) begin
                g = nx(g);
                drive(1'b1, g ^ (32'h1 << $urandom_range(0, 31)), 1'b0, 1'b1);
            end
            else if (r < 83) drive(1'b1, '0, 1'b0, 1'b1);
            else if (r < 88) begin g = $urandom; drive(1'b1, g, 1'b0, 1'b1); end
            else if (r < 93) begin g = nx(g); drive(1'b1, g, 1'b1, 1'b1); end
            else if (r < 95) drive(1'b0, '0, 1'b0, 1'b0);
            else drive(1'b1, $urandom, 1'b0, 1'b1);
        end

        gap();
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
